// File: rtl/contador_modulo_prog.sv
// Programmable-modulus up/down counter with one-shot mode, synchronous preload and
// a modulus change that only takes effect at a wrap or while the counter is stopped.
module contador_modulo_prog #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             up_down,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] modulo,
  input  logic             mod_update,
  output logic [WIDTH-1:0] cuenta,
  output logic [WIDTH-1:0] modulo_actual,
  output logic             fin_cuenta,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cuenta_next;
  logic [WIDTH-1:0] pending;
  logic             pend_valid;
  logic             one_shot_lat;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] wrap_value;
  logic [WIDTH-1:0] load_clamped;
  logic             at_terminal;
  logic             count_en;
  logic             wrap;
  logic             apply_mod;
  logic             start_ok;

  // A down-wrap reloads with the modulus being applied on that same edge,
  // so the pending value is used if one is waiting.
  always_comb begin
    terminal     = up_down ? modulo_actual : '0;
    at_terminal  = (cuenta == terminal);
    count_en     = (state == RUN) && enable && !load && !stop;
    wrap         = count_en && at_terminal;
    apply_mod    = wrap || (state != RUN);
    wrap_value   = pend_valid ? pending : modulo_actual;
    load_clamped = (load_value > modulo_actual) ? modulo_actual : load_value;
    start_ok     = !load && !stop && start && (state != RUN);
    fin_cuenta   = (state == RUN) && enable && at_terminal;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    cuenta_next = cuenta;
    if (load) begin
      cuenta_next = load_clamped;
    end else if (count_en) begin
      if (up_down) cuenta_next = at_terminal ? '0 : cuenta + ONE;
      else         cuenta_next = at_terminal ? wrap_value : cuenta - ONE;
    end
  end

  // load freezes the FSM for that edge; stop beats start.
  always_comb begin
    state_next = state;
    if (!load) begin
      if (stop)                     state_next = IDLE;
      else if (start_ok)            state_next = RUN;
      else if (wrap && one_shot_lat) state_next = DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cuenta        <= '0;
      modulo_actual <= '1;
      pending       <= '1;
      pend_valid    <= 1'b0;
      one_shot_lat  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state  <= state_next;
      cuenta <= cuenta_next;
      busy   <= (state_next == RUN);
      done   <= (state_next == DONE);

      if (start_ok) one_shot_lat <= one_shot;

      if (apply_mod && pend_valid) modulo_actual <= pending;

      // A fresh request on an apply edge stays pending for the next one.
      if (mod_update) begin
        pending    <= modulo;
        pend_valid <= 1'b1;
      end else if (apply_mod) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_contador_modulo_prog.sv
// Self-checking bench for contador_modulo_prog: a vector table replayed through a
// scoreboard queue, plus hand-written reset sequences.
module tb_contador_modulo_prog;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       start;
  logic       stop;
  logic       up_down;
  logic       one_shot;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] modulo;
  logic       mod_update;
  logic [3:0] cuenta;
  logic [3:0] modulo_actual;
  logic       fin_cuenta;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en, st, sp, ud, os, ld;
    logic [3:0] lv;
    logic       mu;
    logic [3:0] mo;
    logic [3:0] c, m;
    logic       f, b, d;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  contador_modulo_prog #(.WIDTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .stop         (stop),
    .up_down      (up_down),
    .one_shot     (one_shot),
    .load         (load),
    .load_value   (load_value),
    .modulo       (modulo),
    .mod_update   (mod_update),
    .cuenta       (cuenta),
    .modulo_actual(modulo_actual),
    .fin_cuenta   (fin_cuenta),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic v(input logic en, st, sp, ud, os, ld, input logic [3:0] lv,
                   input logic mu, input logic [3:0] mo,
                   input logic [3:0] c, m, input logic f, b, d);
    vec_t t;
    t.en = en; t.st = st; t.sp = sp; t.ud = ud; t.os = os; t.ld = ld;
    t.lv = lv; t.mu = mu; t.mo = mo;
    t.c = c; t.m = m; t.f = f; t.b = b; t.d = d;
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    enable = t.en; start = t.st; stop = t.sp; up_down = t.ud; one_shot = t.os;
    load = t.ld; load_value = t.lv; mod_update = t.mu; modulo = t.mo;
  endtask

  task automatic idle_inputs();
    enable = 1'b0; start = 1'b0; stop = 1'b0; up_down = 1'b1; one_shot = 1'b0;
    load = 1'b0; load_value = 4'd0; mod_update = 1'b0; modulo = 4'd0;
  endtask

  initial begin
    vec_t e;
    idle_inputs();
    reset = 1'b1;

    //  en st sp ud os ld  lv   mu mo     cuenta  mod  fin busy done
    // Modulus 5 programmed in IDLE, then count up 0..5,0.
    v(0, 0, 0, 1, 0, 0, 4'd0, 1, 4'd5,  4'd0, 4'd15, 0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd5,  0, 0, 0);
    v(0, 1, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd5,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd1, 4'd5,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd2, 4'd5,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd3, 4'd5,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd4, 4'd5,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd5, 4'd5,  1, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd5,  0, 1, 0);
    // Down: 0 wraps to 5, then 4..0; modulus 3 requested mid-count lands at the wrap.
    v(1, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0,  4'd5, 4'd5,  0, 1, 0);
    v(1, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0,  4'd4, 4'd5,  0, 1, 0);
    v(1, 0, 0, 0, 0, 0, 4'd0, 1, 4'd3,  4'd3, 4'd5,  0, 1, 0);
    v(1, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0,  4'd2, 4'd5,  0, 1, 0);
    v(1, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0,  4'd1, 4'd5,  0, 1, 0);
    v(1, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd5,  1, 1, 0);
    v(1, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0,  4'd3, 4'd3,  0, 1, 0);
    v(1, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0,  4'd2, 4'd3,  0, 1, 0);
    // Stop, program 9, restart, load 12 clamps to 9 and outranks stop.
    v(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd0,  4'd2, 4'd3,  0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 1, 4'd9,  4'd2, 4'd3,  0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd2, 4'd9,  0, 0, 0);
    v(0, 1, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd2, 4'd9,  0, 1, 0);
    v(0, 0, 1, 1, 0, 1, 4'd12, 0, 4'd0, 4'd9, 4'd9,  0, 1, 0);
    v(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd0,  4'd9, 4'd9,  0, 0, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd9, 4'd9,  0, 0, 0);
    // Enable one cycle in three.
    v(0, 1, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd9, 4'd9,  0, 1, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd9, 4'd9,  0, 1, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd9, 4'd9,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd9,  0, 1, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd9,  0, 1, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd9,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd1, 4'd9,  0, 1, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd1, 4'd9,  0, 1, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd1, 4'd9,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd2, 4'd9,  0, 1, 0);
    // One-shot with modulus 3: 0,1,2,3,0 then DONE holding 0; restart from DONE.
    v(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd0,  4'd2, 4'd9,  0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 1, 4'd3,  4'd2, 4'd9,  0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd2, 4'd3,  0, 0, 0);
    v(0, 0, 0, 1, 0, 1, 4'd0, 0, 4'd0,  4'd0, 4'd3,  0, 0, 0);
    v(0, 1, 0, 1, 1, 0, 4'd0, 0, 4'd0,  4'd0, 4'd3,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd1, 4'd3,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd2, 4'd3,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd3, 4'd3,  1, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd3,  0, 0, 1);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd3,  0, 0, 1);
    v(0, 1, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd3,  0, 1, 0);
    // Modulus 0: cuenta pinned at 0, fin_cuenta every enabled cycle, both directions.
    v(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd3,  0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 1, 4'd0,  4'd0, 4'd3,  0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd0,  0, 0, 0);
    v(0, 1, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd0,  0, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd0,  1, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd0,  1, 1, 0);
    v(1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd0,  1, 1, 0);
    v(1, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd0,  1, 1, 0);
    v(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd0,  4'd0, 4'd0,  0, 0, 0);

    // Reset state, with enable high to show fin_cuenta stays low outside RUN.
    enable = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("reset cuenta", 32'(cuenta), 32'd0);
    check("reset modulo_actual", 32'(modulo_actual), 32'd15);
    check("reset fin_cuenta", 32'(fin_cuenta), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        check($sformatf("v%0d scoreboard empty", i), 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d cuenta", i), 32'(cuenta), 32'(e.c));
        check($sformatf("v%0d modulo_actual", i), 32'(modulo_actual), 32'(e.m));
        check($sformatf("v%0d fin_cuenta", i), 32'(fin_cuenta), 32'(e.f));
        check($sformatf("v%0d busy", i), 32'(busy), 32'(e.b));
        check($sformatf("v%0d done", i), 32'(done), 32'(e.d));
      end
    end

    // Reset in the middle of a run while a modulus request is pending.
    @(negedge clock);
    idle_inputs();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    mod_update = 1'b1;
    modulo = 4'd7;
    @(negedge clock);
    mod_update = 1'b0;
    enable = 1'b1;
    #1;
    check("pre-reset fin_cuenta", 32'(fin_cuenta), 32'd1);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrun reset cuenta", 32'(cuenta), 32'd0);
    check("midrun reset modulo_actual", 32'(modulo_actual), 32'd15);
    check("midrun reset fin_cuenta", 32'(fin_cuenta), 32'd0);
    check("midrun reset busy", 32'(busy), 32'd0);
    check("midrun reset done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clock);
    #1;
    check("pending lost modulo_actual", 32'(modulo_actual), 32'd15);
    check("pending lost busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
